// File: rtl/cpu_pipe_pkg.sv
// rtl/cpu_pipe_pkg.sv - shared pipeline types for the MEM/WB elastic stage
package cpu_pipe_pkg;

  // Occupancy of the two-entry MEM/WB stage
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } mem_wb_state_t;

  // Beat layout at the default core widths (32-bit data, 5-bit rd)
  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_to_reg;
  } beat_t;

  // Architectural zero register; writes to it are never qualified
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter (built only with MEM_WB_STATS_EN)
`ifdef MEM_WB_STATS_EN
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count qualifying cycles, sticking at all-ones; only reset clears it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/mem_wb_elastic.sv
// rtl/mem_wb_elastic.sv - MEM->WB elastic stage with skid buffer; optional MEM_WB_STATS_EN counters
module mem_wb_elastic
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
`ifdef MEM_WB_STATS_EN
  ,
  parameter int STAT_W = 16
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_reg_write,
  input  logic              in_mem_to_reg,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_reg_write,
  output logic              out_mem_to_reg,
  output logic              fwd_valid,
  output logic [RD_W-1:0]   fwd_rd,
  output logic [DATA_W-1:0] fwd_data
`ifdef MEM_WB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_stall,
  output logic [STAT_W-1:0] stat_bubble
`endif
);

  // Beat at this instance's widths; same field order as cpu_pipe_pkg::beat_t
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [RD_W-1:0]   rd;
    logic              reg_write;
    logic              mem_to_reg;
  } mem_beat_t;

  mem_wb_state_t r_state;
  logic          r_in_ready;
  mem_beat_t     r_main;
  mem_beat_t     r_skid;
  mem_beat_t     w_in_beat;
  logic          w_in_fire;
  logic          w_out_valid;
  logic          w_out_fire;
  logic          w_out_reg_write;

  assign w_in_beat   = '{data: in_data, rd: in_rd, reg_write: in_reg_write, mem_to_reg: in_mem_to_reg};
  assign w_in_fire   = in_valid && r_in_ready;
  assign w_out_valid = (r_state != EMPTY);
  assign w_out_fire  = w_out_valid && out_ready;

  // Occupancy FSM: main feeds WB, skid catches the beat accepted during a stall
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
      r_main     <= '0;
      r_skid     <= '0;
    end else if (flush) begin
      // Payload is left in place; invalidating the state is enough to kill it
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            r_main  <= w_in_beat;
            r_state <= HALF;
          end
        end
        HALF: begin
          if (w_in_fire && w_out_fire) begin
            r_main <= w_in_beat;
          end else if (w_in_fire) begin
            r_skid     <= w_in_beat;
            r_state    <= FULL;
            r_in_ready <= 1'b0;
          end else if (w_out_fire) begin
            r_state <= EMPTY;
          end
        end
        FULL: begin
          if (w_out_fire) begin
            r_main     <= r_skid;
            r_state    <= HALF;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= EMPTY;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  // Register-file write is qualified by occupancy and never targets r0
  assign w_out_reg_write = w_out_valid && r_main.reg_write && (r_main.rd != RD_W'(REG_ZERO));

  assign in_ready       = r_in_ready;
  assign out_valid      = w_out_valid;
  assign out_data       = r_main.data;
  assign out_rd         = r_main.rd;
  assign out_reg_write  = w_out_reg_write;
  assign out_mem_to_reg = w_out_valid && r_main.mem_to_reg;
  assign fwd_valid      = w_out_reg_write;
  assign fwd_rd         = r_main.rd;
  assign fwd_data       = r_main.data;

`ifdef MEM_WB_STATS_EN
  logic w_stall_inc;
  logic w_bubble_inc;

  assign w_stall_inc  = w_out_valid && !out_ready;
  assign w_bubble_inc = !w_out_valid;

  sat_counter #(.W(STAT_W)) u_stat_stall (
    .clock (clock),
    .reset (reset),
    .inc   (w_stall_inc),
    .count (stat_stall)
  );

  sat_counter #(.W(STAT_W)) u_stat_bubble (
    .clock (clock),
    .reset (reset),
    .inc   (w_bubble_inc),
    .count (stat_bubble)
  );
`endif

endmodule

// File: tb/tb_mem_wb_elastic.sv
// tb/tb_mem_wb_elastic.sv - self-checking bench for mem_wb_elastic (optionally with MEM_WB_STATS_EN)
module tb_mem_wb_elastic;

  localparam int DW      = 32;
  localparam int RW      = 5;
  localparam int TSTAT_W = 4;
  localparam int STAT_MAX = (1 << TSTAT_W) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [RW-1:0] in_rd = '0;
  logic          in_reg_write = 1'b0;
  logic          in_mem_to_reg = 1'b0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [RW-1:0] out_rd;
  logic          out_reg_write;
  logic          out_mem_to_reg;
  logic          fwd_valid;
  logic [RW-1:0] fwd_rd;
  logic [DW-1:0] fwd_data;
`ifdef MEM_WB_STATS_EN
  logic [TSTAT_W-1:0] stat_stall;
  logic [TSTAT_W-1:0] stat_bubble;
`endif

  always #5 clock = ~clock;

  mem_wb_elastic #(
    .DATA_W (DW),
    .RD_W   (RW)
`ifdef MEM_WB_STATS_EN
    ,
    .STAT_W (TSTAT_W)
`endif
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_rd          (in_rd),
    .in_reg_write   (in_reg_write),
    .in_mem_to_reg  (in_mem_to_reg),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_rd         (out_rd),
    .out_reg_write  (out_reg_write),
    .out_mem_to_reg (out_mem_to_reg),
    .fwd_valid      (fwd_valid),
    .fwd_rd         (fwd_rd),
    .fwd_data       (fwd_data)
`ifdef MEM_WB_STATS_EN
    ,
    .stat_stall     (stat_stall),
    .stat_bubble    (stat_bubble)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: an ordered queue of at most two beats plus an accept flag
  typedef struct {
    logic [DW-1:0] d;
    logic [RW-1:0] rd;
    logic          rw;
    logic          m2r;
  } mbeat_t;

  mbeat_t mq[$];
  bit     m_rdy = 1'b1;
  int     m_stall = 0;
  int     m_bubble = 0;

  function automatic void model_reset();
    mq.delete();
    m_rdy    = 1'b1;
    m_stall  = 0;
    m_bubble = 0;
  endfunction

  function automatic void model_step();
    bit     inf;
    bit     outf;
    mbeat_t b;
    if (mq.size() > 0 && !out_ready && m_stall < STAT_MAX) m_stall++;
    if (mq.size() == 0 && m_bubble < STAT_MAX) m_bubble++;
    if (flush) begin
      mq.delete();
      m_rdy = 1'b1;
    end else begin
      inf  = in_valid && m_rdy;
      outf = (mq.size() > 0) && out_ready;
      if (outf) void'(mq.pop_front());
      if (inf) begin
        b.d = in_data; b.rd = in_rd; b.rw = in_reg_write; b.m2r = in_mem_to_reg;
        mq.push_back(b);
      end
      m_rdy = (mq.size() < 2);
    end
  endfunction

  task automatic compare_model(input string tag);
    bit exp_v;
    bit exp_w;
    exp_v = (mq.size() > 0);
    exp_w = exp_v && mq[0].rw && (mq[0].rd != 0);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(m_rdy));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(exp_v));
    chk({tag, ".out_reg_write"}, 32'(out_reg_write), 32'(exp_w));
    chk({tag, ".fwd_valid"}, 32'(fwd_valid), 32'(exp_w));
    if (exp_v) begin
      chk({tag, ".out_data"}, out_data, mq[0].d);
      chk({tag, ".out_rd"}, 32'(out_rd), 32'(mq[0].rd));
      chk({tag, ".out_mem_to_reg"}, 32'(out_mem_to_reg), 32'(mq[0].m2r));
    end
    if (exp_w) begin
      chk({tag, ".fwd_rd"}, 32'(fwd_rd), 32'(mq[0].rd));
      chk({tag, ".fwd_data"}, fwd_data, mq[0].d);
    end
`ifdef MEM_WB_STATS_EN
    chk({tag, ".stat_stall"}, 32'(stat_stall), 32'(m_stall));
    chk({tag, ".stat_bubble"}, 32'(stat_bubble), 32'(m_bubble));
`endif
  endtask

  // Drive one cycle of inputs, advance model and DUT, compare after the edge
  task automatic step(input string tag, input bit iv, input logic [DW-1:0] d, input logic [RW-1:0] rd,
                      input bit rw, input bit m2r, input bit ordy, input bit fl);
    @(negedge clock);
    in_valid = iv; in_data = d; in_rd = rd; in_reg_write = rw; in_mem_to_reg = m2r;
    out_ready = ordy; flush = fl;
    model_step();
    @(posedge clock);
    #1;
    compare_model(tag);
  endtask

  typedef struct {
    bit            iv;
    logic [DW-1:0] d;
    logic [RW-1:0] rd;
    bit            rw;
    bit            m2r;
    bit            ordy;
    bit            fl;
    bit            e_ov;
    bit            e_ir;
    logic [DW-1:0] e_d;
    bit            e_rw;
  } vec_t;

  function automatic vec_t mk(bit iv, logic [DW-1:0] d, logic [RW-1:0] rd, bit rw, bit m2r, bit ordy,
                              bit fl, bit e_ov, bit e_ir, logic [DW-1:0] e_d, bit e_rw);
    vec_t v;
    v.iv = iv; v.d = d; v.rd = rd; v.rw = rw; v.m2r = m2r; v.ordy = ordy; v.fl = fl;
    v.e_ov = e_ov; v.e_ir = e_ir; v.e_d = e_d; v.e_rw = e_rw;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    // Directed vectors: inputs for one cycle, expected outputs just after that edge
    tbl.push_back(mk(0, 32'h0,    5'd0, 0, 0, 1, 0, 0, 1, 32'h0,    0)); // idle
    tbl.push_back(mk(1, 32'h11,   5'd3, 1, 0, 1, 0, 1, 1, 32'h11,   1)); // stream
    tbl.push_back(mk(1, 32'h22,   5'd3, 1, 0, 1, 0, 1, 1, 32'h22,   1));
    tbl.push_back(mk(1, 32'h33,   5'd3, 1, 0, 1, 0, 1, 1, 32'h33,   1));
    tbl.push_back(mk(0, 32'h0,    5'd0, 0, 0, 1, 0, 0, 1, 32'h0,    0));
    tbl.push_back(mk(1, 32'hA0,   5'd5, 1, 0, 0, 0, 1, 1, 32'hA0,   1)); // A held
    tbl.push_back(mk(1, 32'hB0,   5'd6, 1, 0, 0, 0, 1, 0, 32'hA0,   1)); // B to skid
    tbl.push_back(mk(1, 32'hC0,   5'd9, 1, 0, 0, 0, 1, 0, 32'hA0,   1)); // C refused
    tbl.push_back(mk(0, 32'h0,    5'd0, 0, 0, 1, 0, 1, 1, 32'hB0,   1)); // A out, B to main
    tbl.push_back(mk(0, 32'h0,    5'd0, 0, 0, 1, 0, 0, 1, 32'h0,    0)); // B out
    tbl.push_back(mk(1, 32'hDEAD, 5'd0, 1, 0, 0, 0, 1, 1, 32'hDEAD, 0)); // r0 write
    tbl.push_back(mk(0, 32'h0,    5'd0, 0, 0, 1, 0, 0, 1, 32'h0,    0));
    tbl.push_back(mk(1, 32'hE1,   5'd7, 1, 0, 0, 0, 1, 1, 32'hE1,   1));
    tbl.push_back(mk(1, 32'hE2,   5'd7, 1, 0, 0, 0, 1, 0, 32'hE1,   1)); // FULL
    tbl.push_back(mk(1, 32'hE3,   5'd7, 1, 0, 0, 1, 0, 1, 32'h0,    0)); // flush
    tbl.push_back(mk(0, 32'h0,    5'd0, 0, 0, 1, 0, 0, 1, 32'h0,    0)); // nothing reappears
    tbl.push_back(mk(1, 32'hF1,   5'd8, 1, 1, 1, 0, 1, 1, 32'hF1,   1));
    tbl.push_back(mk(0, 32'h0,    5'd0, 0, 0, 1, 0, 0, 1, 32'h0,    0));

    model_reset();
    repeat (3) @(posedge clock);
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data", out_data, 32'd0);
    chk("rst.out_rd", 32'(out_rd), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("idle.out_reg_write", 32'(out_reg_write), 32'd0);
    chk("idle.out_mem_to_reg", 32'(out_mem_to_reg), 32'd0);
    chk("idle.fwd_valid", 32'(fwd_valid), 32'd0);
    chk("idle.fwd_rd", 32'(fwd_rd), 32'd0);
    chk("idle.fwd_data", fwd_data, 32'd0);
    model_step();
    compare_model("idle");

    for (int i = 0; i < tbl.size(); i++) begin
      step($sformatf("tbl%0d", i), tbl[i].iv, tbl[i].d, tbl[i].rd, tbl[i].rw, tbl[i].m2r,
           tbl[i].ordy, tbl[i].fl);
      chk($sformatf("tbl%0d.ov", i), 32'(out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("tbl%0d.ir", i), 32'(in_ready), 32'(tbl[i].e_ir));
      if (tbl[i].e_ov) begin
        chk($sformatf("tbl%0d.data", i), out_data, tbl[i].e_d);
        chk($sformatf("tbl%0d.rw", i), 32'(out_reg_write), 32'(tbl[i].e_rw));
      end
    end

`ifdef MEM_WB_STATS_EN
    // Hold one beat under backpressure long enough to saturate the stall counter
    step("sat.load", 1, 32'h55, 5'd4, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) step("sat.hold", 0, 32'h0, 5'd0, 0, 0, 0, 0);
    chk("sat.stat_stall", 32'(stat_stall), 32'd15);
    step("sat.flush", 0, 32'h0, 5'd0, 0, 0, 0, 1);
    chk("sat.stall_kept", 32'(stat_stall), 32'd15);
`endif

    // Randomised traffic including r0 targets, stalls and occasional flushes
    for (int i = 0; i < 400; i++) begin
      step("rnd", ($urandom % 4) != 0, $urandom, 5'($urandom % 8), 1'($urandom), 1'($urandom),
           ($urandom % 3) != 0, ($urandom % 32) == 0);
    end

    // Asynchronous reset while FULL discards both entries immediately
    step("ar.a", 1, 32'h71, 5'd2, 1, 0, 0, 0);
    step("ar.b", 1, 32'h72, 5'd2, 1, 0, 0, 0);
    @(negedge clock);
    in_valid = 1'b1; flush = 1'b1; out_ready = 1'b0;
    reset = 1'b1;
    #1;
    model_reset();
    chk("ar.out_valid", 32'(out_valid), 32'd0);
    chk("ar.in_ready", 32'(in_ready), 32'd1);
    chk("ar.out_data", out_data, 32'd0);
    chk("ar.fwd_valid", 32'(fwd_valid), 32'd0);
    @(posedge clock);
    #1;
    compare_model("ar.hold");
    @(negedge clock);
    reset = 1'b0;
    step("ar.idle", 0, 32'h0, 5'd0, 0, 0, 1, 0);
    step("ar.beat", 1, 32'h99, 5'd1, 1, 0, 1, 0);
    step("ar.drain", 0, 32'h0, 5'd0, 0, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
